sram_arb: RTL and testbench
===========================

# sram_arb

Two-port request arbiter and sequencer that sits in front of the external SRAM strobe controller and drives its single-cycle read/write strobes. It accepts level-held requests from the CPU bus (port A) and the video fetch path (port B), grants one at a time round-robin, and holds address and write data stable for the full access. It captures read data at the cycle fixed by the controller's strobe timing and returns a one-cycle acknowledge to the winning port.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 8, SRAM data width

- iClk  in  1  system clock; all logic on rising edge
- iRstN  in  1  synchronous, active-low reset
- iAReq  in  1  port A request, held until oAAck
- iAWr  in  1  port A: 1 write, 0 read; valid with iAReq
- iAAddr  in  ADDR_W  port A address
- iAWData  in  DATA_W  port A write data
- oAAck  out  1  port A one-cycle completion pulse
- oARData  out  DATA_W  port A read data, valid while oAAck=1
- iBReq, iBWr, iBAddr, iBWData, oBAck, oBRData: same as port A, for port B
- oRd  out  1  one-cycle read strobe to the strobe controller
- oWr  out  1  one-cycle write strobe to the strobe controller
- oAddr  out  ADDR_W  SRAM address pins
- oWData  out  DATA_W  data driven to the SRAM bus (direction handled by the controller)
- iRData  in  DATA_W  data sampled from the SRAM bus

## Operation
- States: IDLE, ISSUE, HOLD, DONE. All outputs are registered.
- In IDLE, the block computes the eligible requests. A port's request is eligible when its Req=1 and its Ack is not high in this cycle.
  - None eligible: stay in IDLE.
  - One eligible: grant that port.
  - Both eligible: grant the port not served last.
  - On grant: latch Wr, Addr and WData into oAddr/oWData, record the granted port, and go to ISSUE.
- ISSUE: oRd=~wr or oWr=wr, high for this cycle only. Go to HOLD.
- HOLD: strobes are 0. Go to DONE.
- DONE: strobes are 0.
  - At the closing edge, for a read, register iRData into the granted port's RData.
  - At the same edge, set the granted port's Ack, update the last-served flag, and go to IDLE.
- Ack is high for exactly the first IDLE cycle after DONE.
  - The other port can be granted in that same cycle.
  - The just-served port is masked for that cycle. A registered requester therefore drops Req without causing a double grant.
- Port RData holds its last captured value until the next read on that port. Writes leave RData unchanged.
- The block ignores requester-side changes to Addr, WData or Wr after grant.
- iAWr/iBWr are sampled only at grant.
- Reset values: state IDLE, oRd=0, oWr=0, oAAck=0, oBAck=0, oAddr=0, oWData=0, oARData=0, oBRData=0, last-served=B (so A wins the first tie).
- If reset is asserted mid-access, the access is abandoned with no Ack. All registers take their reset values at the next edge.

## Timing
- Grant at edge G (end of the IDLE cycle). Strobe is high in cycle G+1 (ISSUE).
- The controller drives OE/WE low for the two cycles after the strobe edge (HOLD and DONE).
- iRData is sampled at the end of DONE, i.e. 3 edges after grant.
- Ack and RData are visible in cycle G+4.
- Request-to-ack latency: 4 cycles from the cycle Req is first seen idle-eligible.
- Sustained throughput: one access per 4 cycles when requests alternate. A single port repeating back to back gets one access per 5 cycles because of the one-cycle mask.
- oAddr/oWData are stable from ISSUE through the end of DONE.
- oRd and oWr are never high together. No strobe occurs within 3 cycles of the previous strobe, which respects the controller's busy cycle.
- After reset release, the first strobe occurs no earlier than the second cycle.

## Structure
- The shared SRAM header, sram_defs.vh, holds:
  - state encodings IDLE/ISSUE/HOLD/DONE;
  - SRAM_CAPTURE_DLY = 2, the strobe-to-capture edge count;
  - the default ADDR_W/DATA_W.
- No sub-module. Arbitration is a small combinational round-robin picker inside this module.

## Test plan
- Single read on A: iAAddr=0x12345, iAWr=0, iRData=0xA5 during DONE → oRd high for exactly one cycle with oAddr=0x12345; oAAck in cycle G+4; oARData=0xA5.
- Single write on B: iBAddr=0x00FF0, iBWData=0x3C → oWr high for one cycle; oAddr/oWData stable through DONE; oBAck at G+4; oBRData unchanged.
- Simultaneous requests after reset: A and B both read → A served first, B granted in A's ack cycle. Then with both held again, order alternates A, B, A.
- Held request: A keeps Req=1 for one cycle after oAAck → no second grant in the ack cycle. A is re-granted only if Req is still high in the following IDLE cycle.
- Requester changes iAAddr to 0x00001 during HOLD → oAddr stays at the latched 0x12345.
- Reset pulled low during HOLD of a read → next cycle all outputs are at reset values, no Ack. After release, A's held request is serviced normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared SRAM access definitions: FSM state encodings, strobe-to-capture delay,
// default bus widths and the two-port round-robin pick.
package sram_arb_pkg;

    localparam int ADDR_W_DEF       = 20;
    localparam int DATA_W_DEF       = 8;
    localparam int SRAM_CAPTURE_DLY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // On a tie the port that was not served last wins.
    function automatic port_t rr_pick(input logic a_elig, input logic b_elig, input port_t last);
        if (a_elig && b_elig) begin
            return (last == PORT_B) ? PORT_A : PORT_B;
        end
        return a_elig ? PORT_A : PORT_B;
    endfunction

endpackage

// File: rtl/sram_arb.sv
// Two-port round-robin sequencer for the SRAM strobe controller; grant-to-ack 4 cycles.
// Requests are level-held until a one-cycle ack; the just-acked port is masked for that cycle.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iAReq,
    input  logic              iAWr,
    input  logic [ADDR_W-1:0] iAAddr,
    input  logic [DATA_W-1:0] iAWData,
    output logic              oAAck,
    output logic [DATA_W-1:0] oARData,
    input  logic              iBReq,
    input  logic              iBWr,
    input  logic [ADDR_W-1:0] iBAddr,
    input  logic [DATA_W-1:0] iBWData,
    output logic              oBAck,
    output logic [DATA_W-1:0] oBRData,
    output logic              oRd,
    output logic              oWr,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oWData,
    input  logic [DATA_W-1:0] iRData
);

    // HOLD lasts until the controller's capture edge, SRAM_CAPTURE_DLY edges after the strobe.
    localparam logic [1:0] CNT_INIT = 2'(SRAM_CAPTURE_DLY - 2);

    state_t      r_state;
    port_t       r_port;
    port_t       r_last;
    logic        r_wr;
    logic [1:0]  r_cnt;

    state_t              w_state_nxt;
    logic                w_grant;
    port_t               w_gnt_port;
    logic                w_gnt_wr;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_wdata;
    logic                w_a_elig;
    logic                w_b_elig;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_a_elig    = iAReq & ~oAAck;
        w_b_elig    = iBReq & ~oBAck;
        w_gnt_port  = rr_pick(w_a_elig, w_b_elig, r_last);
        w_gnt_wr    = (w_gnt_port == PORT_A) ? iAWr    : iBWr;
        w_gnt_addr  = (w_gnt_port == PORT_A) ? iAAddr  : iBAddr;
        w_gnt_wdata = (w_gnt_port == PORT_A) ? iAWData : iBWData;
        case (r_state)
            ST_IDLE: begin
                if (w_a_elig || w_b_elig) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_HOLD;
            ST_HOLD:  if (r_cnt == 2'd0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_state <= ST_IDLE;
            r_port  <= PORT_A;
            r_last  <= PORT_B;
            r_wr    <= 1'b0;
            r_cnt   <= 2'd0;
            oRd     <= 1'b0;
            oWr     <= 1'b0;
            oAAck   <= 1'b0;
            oBAck   <= 1'b0;
            oAddr   <= '0;
            oWData  <= '0;
            oARData <= '0;
            oBRData <= '0;
        end else begin
            r_state <= w_state_nxt;
            oRd     <= w_grant & ~w_gnt_wr;
            oWr     <= w_grant &  w_gnt_wr;
            oAAck   <= 1'b0;
            oBAck   <= 1'b0;
            if (w_grant) begin
                oAddr  <= w_gnt_addr;
                oWData <= w_gnt_wdata;
                r_wr   <= w_gnt_wr;
                r_port <= w_gnt_port;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == ST_HOLD && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (r_state == ST_DONE) begin
                if (!r_wr && r_port == PORT_A) oARData <= iRData;
                if (!r_wr && r_port == PORT_B) oBRData <= iRData;
                oAAck  <= (r_port == PORT_A);
                oBAck  <= (r_port == PORT_B);
                r_last <= r_port;
            end
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// Directed scenarios plus randomized two-port traffic against a timeline reference model.
module tb_sram_arb;

    localparam int AW = 20;
    localparam int DW = 8;
    localparam int OW = 2 + AW + DW + 2 + 2 * DW;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iAReq, iAWr, iBReq, iBWr;
    logic [AW-1:0] iAAddr, iBAddr;
    logic [DW-1:0] iAWData, iBWData, iRData;
    logic          oAAck, oBAck, oRd, oWr;
    logic [DW-1:0] oARData, oBRData, oWData;
    logic [AW-1:0] oAddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 iClk = ~iClk;

    sram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iAReq(iAReq), .iAWr(iAWr), .iAAddr(iAAddr), .iAWData(iAWData),
        .oAAck(oAAck), .oARData(oARData),
        .iBReq(iBReq), .iBWr(iBWr), .iBAddr(iBAddr), .iBWData(iBWData),
        .oBAck(oBAck), .oBRData(oBRData),
        .oRd(oRd), .oWr(oWr), .oAddr(oAddr), .oWData(oWData), .iRData(iRData)
    );

    // Reference model: an access occupies a fixed 4-cycle timeline after its grant edge;
    // m_age counts cycles since grant (0 = arbiter free).
    int            m_age  = 0;
    bit            m_last = 1'b1;
    bit            m_port = 1'b0;
    bit            m_wr   = 1'b0;
    logic          e_rd = 0, e_wr = 0, e_aack = 0, e_back = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_ard = '0, e_brd = '0;

    always @(posedge iClk) begin : model
        bit ea, eb, pb;
        if (!iRstN) begin
            m_age = 0; m_last = 1'b1; m_port = 1'b0; m_wr = 1'b0;
            e_rd = 0; e_wr = 0; e_aack = 0; e_back = 0;
            e_addr = '0; e_wdata = '0; e_ard = '0; e_brd = '0;
        end else begin
            ea = iAReq && !e_aack;
            eb = iBReq && !e_back;
            e_rd = 0; e_wr = 0; e_aack = 0; e_back = 0;
            if (m_age == 0) begin
                if (ea || eb) begin
                    pb      = (ea && eb) ? (m_last == 1'b0) : eb;
                    m_port  = pb;
                    m_wr    = pb ? iBWr : iAWr;
                    e_addr  = pb ? iBAddr : iAAddr;
                    e_wdata = pb ? iBWData : iAWData;
                    e_rd    = !m_wr;
                    e_wr    = m_wr;
                    m_age   = 1;
                end
            end else if (m_age == 3) begin
                if (!m_wr && m_port)  e_brd = iRData;
                if (!m_wr && !m_port) e_ard = iRData;
                if (m_port) e_back = 1; else e_aack = 1;
                m_last = m_port;
                m_age  = 0;
            end else begin
                m_age = m_age + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iAReq = 0; iBReq = 0; iAWr = 0; iBWr = 0;
    endtask

    task automatic test_reset();
        iRstN = 0; idle_inputs();
        iAAddr = '0; iBAddr = '0; iAWData = '0; iBWData = '0; iRData = '0;
        cyc(); cyc();
        n_vec++;
        if ({oRd, oWr, oAAck, oBAck} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 0000", {oRd, oWr, oAAck, oBAck});
        end
        n_vec++;
        if ({oAddr, oWData} !== '0) begin
            n_err++; $display("FAIL reset_bus: got addr %h wdata %h want 0", oAddr, oWData);
        end
        n_vec++;
        if ({oARData, oBRData} !== '0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h want 0", oARData, oBRData);
        end
        iRstN = 1;
    endtask

    task automatic test_single_read_a();
        iAReq = 1; iAWr = 0; iAAddr = 20'h12345; iRData = 8'h00;
        cyc();
        n_vec++;
        if ({oRd, oWr, oAddr} !== {1'b1, 1'b0, 20'h12345}) begin
            n_err++; $display("FAIL rd_a_strobe: got rd %b wr %b addr %h want 1 0 12345", oRd, oWr, oAddr);
        end
        cyc();
        n_vec++;
        if (oRd !== 1'b0) begin
            n_err++; $display("FAIL rd_a_one_cycle: got rd %b want 0", oRd);
        end
        cyc();
        iRData = 8'hA5;
        n_vec++;
        if (oAAck !== 1'b0) begin
            n_err++; $display("FAIL rd_a_early_ack: got %b want 0", oAAck);
        end
        cyc();
        n_vec++;
        if ({oAAck, oBAck, oARData} !== {1'b1, 1'b0, 8'hA5}) begin
            n_err++; $display("FAIL rd_a_ack: got ack %b/%b data %h want 1/0 a5", oAAck, oBAck, oARData);
        end
        iAReq = 0; iRData = 8'h00;
        cyc();
        n_vec++;
        if ({oAAck, oARData} !== {1'b0, 8'hA5}) begin
            n_err++; $display("FAIL rd_a_after: got ack %b data %h want 0 a5", oAAck, oARData);
        end
    endtask

    task automatic test_single_write_b();
        iBReq = 1; iBWr = 1; iBAddr = 20'h00FF0; iBWData = 8'h3C;
        cyc();
        n_vec++;
        if ({oRd, oWr, oAddr, oWData} !== {1'b0, 1'b1, 20'h00FF0, 8'h3C}) begin
            n_err++; $display("FAIL wr_b_strobe: got rd %b wr %b addr %h d %h", oRd, oWr, oAddr, oWData);
        end
        for (int i = 0; i < 2; i++) begin
            iBWData = 8'(i + 1);
            cyc();
            n_vec++;
            if ({oWr, oAddr, oWData} !== {1'b0, 20'h00FF0, 8'h3C}) begin
                n_err++; $display("FAIL wr_b_hold%0d: got wr %b addr %h d %h", i, oWr, oAddr, oWData);
            end
        end
        cyc();
        n_vec++;
        if ({oBAck, oBRData, oARData} !== {1'b1, 8'h00, 8'hA5}) begin
            n_err++; $display("FAIL wr_b_ack: got ack %b brd %h ard %h want 1 00 a5", oBAck, oBRData, oARData);
        end
        iBReq = 0; iBWr = 0;
        cyc();
    endtask

    task automatic test_tie();
        int order[$];
        int when[$];
        iRstN = 0;
        iAReq = 1; iBReq = 1; iAWr = 0; iBWr = 0;
        iAAddr = 20'h0AAAA; iBAddr = 20'h0BBBB; iRData = 8'h11;
        cyc();
        iRstN = 1;
        cyc();
        n_vec++;
        if ({oRd, oAddr} !== {1'b1, 20'h0AAAA}) begin
            n_err++; $display("FAIL tie_first: got rd %b addr %h want 1 0aaaa", oRd, oAddr);
        end
        cyc(); cyc(); cyc();
        n_vec++;
        if ({oAAck, oARData, oRd} !== {1'b1, 8'h11, 1'b0}) begin
            n_err++; $display("FAIL tie_a_ack: got ack %b data %h rd %b", oAAck, oARData, oRd);
        end
        iAReq = 0; iRData = 8'h22;
        cyc();
        n_vec++;
        if ({oRd, oAddr} !== {1'b1, 20'h0BBBB}) begin
            n_err++; $display("FAIL tie_b_grant: got rd %b addr %h want 1 0bbbb", oRd, oAddr);
        end
        cyc(); cyc(); cyc();
        n_vec++;
        if ({oBAck, oBRData} !== {1'b1, 8'h22}) begin
            n_err++; $display("FAIL tie_b_ack: got ack %b data %h want 1 22", oBAck, oBRData);
        end
        iAReq = 1;
        for (int c = 0; c < 24 && order.size() < 3; c++) begin
            cyc();
            if (oRd) begin
                order.push_back((oAddr == 20'h0AAAA) ? 0 : 1);
                when.push_back(c);
            end
        end
        n_vec++;
        if (order.size() != 3) begin
            n_err++; $display("FAIL tie_count: got %0d strobes want 3", order.size());
        end else begin
            n_vec++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
                n_err++; $display("FAIL tie_order: got %0d%0d%0d want 010", order[0], order[1], order[2]);
            end
            n_vec++;
            if (when[1] - when[0] != 4 || when[2] - when[1] != 4) begin
                n_err++; $display("FAIL tie_spacing: got %0d %0d want 4 4", when[1] - when[0], when[2] - when[1]);
            end
        end
        idle_inputs();
        repeat (8) cyc();
    endtask

    task automatic test_held_req();
        int c;
        iAReq = 1; iAWr = 0; iAAddr = 20'h00123;
        c = 0;
        while (oAAck !== 1'b1 && c < 12) begin
            cyc(); c++;
        end
        n_vec++;
        if (oAAck !== 1'b1) begin
            n_err++; $display("FAIL held_ack_timeout: got no ack in %0d cycles want ack", c);
        end
        cyc();
        n_vec++;
        if (oRd !== 1'b0) begin
            n_err++; $display("FAIL held_masked: got rd %b want 0", oRd);
        end
        cyc();
        n_vec++;
        if (oRd !== 1'b1) begin
            n_err++; $display("FAIL held_regrant: got rd %b want 1", oRd);
        end
        iAReq = 0;
        cyc(); cyc(); cyc();
        n_vec++;
        if (oAAck !== 1'b1) begin
            n_err++; $display("FAIL held_second_ack: got %b want 1", oAAck);
        end
        cyc();
    endtask

    task automatic test_addr_change();
        iAReq = 1; iAWr = 0; iAAddr = 20'h12345; iRData = 8'h5A;
        cyc();
        cyc();
        iAAddr = 20'h00001; iAWr = 1; iAWData = 8'hFF;
        cyc();
        n_vec++;
        if ({oAddr, oWr} !== {20'h12345, 1'b0}) begin
            n_err++; $display("FAIL addr_stable: got addr %h wr %b want 12345 0", oAddr, oWr);
        end
        cyc();
        n_vec++;
        if ({oAAck, oARData} !== {1'b1, 8'h5A}) begin
            n_err++; $display("FAIL addr_chg_ack: got ack %b data %h want 1 5a", oAAck, oARData);
        end
        iAReq = 0; iAWr = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        iAReq = 1; iAWr = 0; iAAddr = 20'h00777; iRData = 8'h77;
        cyc();
        cyc();
        iRstN = 0;
        cyc();
        n_vec++;
        if ({oRd, oWr, oAAck, oBAck, oAddr, oWData, oARData, oBRData} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got rd %b wr %b ack %b%b addr %h ard %h want 0",
                              oRd, oWr, oAAck, oBAck, oAddr, oARData);
        end
        iRstN = 1;
        cyc();
        n_vec++;
        if ({oRd, oAddr} !== {1'b1, 20'h00777}) begin
            n_err++; $display("FAIL rstmid_regrant: got rd %b addr %h want 1 00777", oRd, oAddr);
        end
        cyc(); cyc();
        n_vec++;
        if (oAAck !== 1'b0) begin
            n_err++; $display("FAIL rstmid_early_ack: got %b want 0", oAAck);
        end
        cyc();
        n_vec++;
        if ({oAAck, oARData} !== {1'b1, 8'h77}) begin
            n_err++; $display("FAIL rstmid_ack: got ack %b data %h want 1 77", oAAck, oARData);
        end
        iAReq = 0;
        cyc();
    endtask

    task automatic test_random();
        logic [OW-1:0] got, exp;
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            got = {oRd, oWr, oAddr, oWData, oAAck, oBAck, oARData, oBRData};
            exp = {e_rd, e_wr, e_addr, e_wdata, e_aack, e_back, e_ard, e_brd};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_cycle%0d: got %h want %h", c, got, exp);
                bad++;
            end
            n_vec++;
            if (oRd === 1'b1 && oWr === 1'b1) begin
                n_err++; $display("FAIL rand_both_strobes: got rd %b wr %b want not both", oRd, oWr);
            end
            iRData = DW'($urandom);
            iRstN  = ($urandom_range(0, 399) != 0);
            if (iAReq) begin
                if (oAAck && $urandom_range(0, 1) == 1) iAReq = 0;
                if ($urandom_range(0, 7) == 0) iAAddr = AW'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                iAReq = 1; iAWr = 1'($urandom_range(0, 1));
                iAAddr = AW'($urandom); iAWData = DW'($urandom);
            end
            if (iBReq) begin
                if (oBAck && $urandom_range(0, 1) == 1) iBReq = 0;
                if ($urandom_range(0, 7) == 0) iBWData = DW'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                iBReq = 1; iBWr = 1'($urandom_range(0, 1));
                iBAddr = AW'($urandom); iBWData = DW'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read_a();
        test_single_write_b();
        test_tie();
        test_held_req();
        test_addr_change();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
